// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter that has no busy/done signal.
// This block owns frame timing: en is high for one frame per byte, followed by a guard gap.
module uart_tx_buffer #(
    parameter int CLK_FREQ   = 100000000,
    parameter int Baud       = 9600,
    parameter int FRAME_BITS = 12,
    parameter int GAP_BITS   = 2,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     flush,
    output logic [7:0]               data_send,
    output logic                     en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int BIT_CYCLES   = CLK_FREQ / Baud;
    localparam int FRAME_CYCLES = FRAME_BITS * BIT_CYCLES;
    localparam int GAP_CYCLES   = GAP_BITS * BIT_CYCLES;
    localparam int AW           = $clog2(DEPTH);
    localparam int CW           = AW + 1;
    localparam int TMAX         = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int TW           = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      data_send_q, data_send_d;
    logic            en_q, en_d;
    logic [7:0]      mem [DEPTH];
    logic            push;
    logic            pop;

    assign wr_ready  = (count_q != FULL_COUNT);
    assign count     = count_q;
    assign data_send = data_send_q;
    assign en        = en_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);

    // Flush wins over both a same-cycle write and a pop from IDLE.
    always_comb begin
        push     = wr_valid && wr_ready && !flush;
        pop      = (state_q == IDLE) && (count_q != '0) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        data_send_d = data_send_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_send_d = mem[rd_ptr_q];
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = SEND;
            end
            SEND: begin
                if (timer_q == FRAME_LAST) begin
                    timer_d = '0;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
        // en is registered from the next state so it is glitch-free and exactly one frame long.
        en_d = (state_d == SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_send_q <= 8'h00;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_send_q <= data_send_d;
            en_q        <= en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule
